// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame constants for the 8N1 UART
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int CNT_W      = 16;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - receiver: input synchronizer, 8N1 deframing FSM, holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 deq_ready,
  output logic                 deq_valid,
  output logic [DATA_BITS-1:0] deq_bits
);

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

  rx_state_t              state;
  logic [1:0]             sync;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_BITS-1:0]   shift;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync      <= 2'b11;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      deq_valid <= 1'b0;
      deq_bits  <= '0;
    end else begin
      sync <= {sync[0], rxd};
      // A completing byte below overrides this clear (overrun / same-cycle dequeue).
      if (deq_valid && deq_ready) deq_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              deq_bits  <= shift;
              deq_valid <= 1'b1;
              state     <= RX_IDLE;
            end else begin
              state <= RX_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 UART top: transmitter FSM plus the uart_rx receiver
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_ctl_enq_valid,
  input  logic [DATA_BITS-1:0] io_ctl_enq_bits,
  output logic                 io_ctl_enq_ready,
  output logic                 io_ctl_deq_valid,
  output logic [DATA_BITS-1:0] io_ctl_deq_bits,
  input  logic                 io_ctl_deq_ready,
  input  logic                 io_pins_rxd,
  output logic                 io_pins_txd
);

  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_t             tx_state;
  logic [CNT_W-1:0]      tx_cnt;
  logic [BIT_IDX_W-1:0]  tx_bit;
  logic [DATA_BITS-1:0]  tx_shift;

  // txd is registered so each line level is driven for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state         <= TX_IDLE;
      tx_cnt           <= '0;
      tx_bit           <= '0;
      tx_shift         <= '0;
      io_pins_txd      <= 1'b1;
      io_ctl_enq_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (io_ctl_enq_valid) begin
            tx_shift         <= io_ctl_enq_bits;
            tx_cnt           <= '0;
            tx_state         <= TX_START;
            io_pins_txd      <= 1'b0;
            io_ctl_enq_ready <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_state    <= TX_DATA;
            io_pins_txd <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              tx_state    <= TX_STOP;
              io_pins_txd <= 1'b1;
            end else begin
              tx_bit      <= tx_bit + 1'b1;
              tx_shift    <= tx_shift >> 1;
              io_pins_txd <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt           <= '0;
            tx_state         <= TX_IDLE;
            io_ctl_enq_ready <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (io_pins_rxd),
    .deq_ready(io_ctl_deq_ready),
    .deq_valid(io_ctl_deq_valid),
    .deq_bits (io_ctl_deq_bits)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - scoreboard bench for uart_core with CLKS_PER_BIT=4
module tb_uart_core;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enq_valid = 1'b0;
  logic [7:0] enq_bits = 8'h00;
  logic       deq_ready = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;
  logic       enq_ready, deq_valid, txd;
  logic [7:0] deq_bits;
  logic       rxd;

  assign rxd = loop ? txd : rxd_drv;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  bit tx_mon_en = 1'b0;
  bit rx_mon_en = 1'b0;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_ctl_enq_valid(enq_valid),
    .io_ctl_enq_bits (enq_bits),
    .io_ctl_enq_ready(enq_ready),
    .io_ctl_deq_valid(deq_valid),
    .io_ctl_deq_bits (deq_bits),
    .io_ctl_deq_ready(deq_ready),
    .io_pins_rxd     (rxd),
    .io_pins_txd     (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of serial bit k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == FRAME_BITS - 1) return 1'b1;
    return b[k-1];
  endfunction

  // TX monitor: decode frames at mid-bit and compare against the expected queue.
  initial begin
    logic       prev;
    logic [7:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev && !txd) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", txd, 1);
        check("tx_queue_nonempty", tx_exp.size() != 0, 1);
        if (tx_exp.size() != 0) check("tx_byte", got, tx_exp.pop_front());
        prev = 1'b1;
      end else begin
        prev = txd;
      end
    end
  end

  // RX monitor: every handshake delivers the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_mon_en && deq_valid && deq_ready) begin
        check("rx_queue_nonempty", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) check("rx_byte", deq_bits, rx_exp.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!enq_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!enq_ready) check("enq_ready_timeout", enq_ready, 1);
  endtask

  task automatic wait_deq();
    int n = 0;
    while (!deq_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!deq_valid) check("deq_valid_timeout", deq_valid, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    enq_bits  = b;
    enq_valid = 1'b1;
    @(negedge clk);
    enq_valid = 1'b0;
    enq_bits  = 8'($urandom);
  endtask

  task automatic rx_send(input logic [7:0] b);
    for (int k = 0; k < FRAME_BITS; k++) begin
      rxd_drv = frame_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic consume();
    deq_ready = 1'b1;
    @(negedge clk);
    deq_ready = 1'b0;
    check("deq_valid_cleared", deq_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         n;
    bit         seen;

    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_bits", deq_bits, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_txd", txd, 1);
    check("post_rst_enq_ready", enq_ready, 1);
    check("post_rst_deq_valid", deq_valid, 0);

    // Exact FE waveform.
    tx_mon_en = 1'b1;
    tx_exp.push_back(8'hFE);
    enq_bits  = 8'hFE;
    enq_valid = 1'b1;
    @(negedge clk);
    enq_valid = 1'b0;
    enq_bits  = 8'h00;
    check("fe_ready_drop", enq_ready, 0);
    for (int k = 0; k < frame_cycles(CPB); k++) begin
      if (k > 0) @(negedge clk);
      check("fe_wave", txd, frame_bit(8'hFE, k / CPB));
    end
    @(negedge clk);
    check("fe_ready_back", enq_ready, 1);
    check("fe_txd_idle", txd, 1);

    // Loopback A5 held in the holding register.
    loop = 1'b1;
    tx_exp.push_back(8'hA5);
    send(8'hA5);
    wait_deq();
    check("a5_bits", deq_bits, 8'hA5);
    repeat (5) @(negedge clk);
    check("a5_stable", deq_bits, 8'hA5);
    consume();

    // Line stuck low: framing error, then recovery.
    wait_ready();
    loop = 1'b0;
    rxd_drv = 1'b0;
    seen = 1'b0;
    repeat (15 * CPB) begin
      @(negedge clk);
      if (deq_valid) seen = 1'b1;
    end
    check("ferr_no_valid", seen, 0);
    rxd_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("ferr_still_no_valid", deq_valid, 0);
    rx_send(8'h3C);
    wait_deq();
    check("ferr_recover_bits", deq_bits, 8'h3C);
    consume();

    // Back-to-back TX with valid held, and overrun in RX.
    loop = 1'b1;
    tx_exp.push_back(8'h11);
    tx_exp.push_back(8'h22);
    enq_bits  = 8'h11;
    enq_valid = 1'b1;
    @(negedge clk);
    check("b2b_first_start", txd, 0);
    enq_bits = 8'h22;
    n = 0;
    while (!enq_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_cycle", n, frame_cycles(CPB));
    @(negedge clk);
    enq_valid = 1'b0;
    check("b2b_second_start", txd, 0);
    check("b2b_second_busy", enq_ready, 0);
    wait_ready();
    repeat (10) @(negedge clk);
    check("overrun_valid", deq_valid, 1);
    check("overrun_bits", deq_bits, 8'h22);
    consume();

    // One-cycle glitch, then a real byte proves RX is idle again.
    loop = 1'b0;
    rxd_drv = 1'b0;
    @(negedge clk);
    rxd_drv = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (deq_valid) seen = 1'b1;
    end
    check("glitch_no_byte", seen, 0);
    rx_send(8'h5A);
    wait_deq();
    check("glitch_recover_bits", deq_bits, 8'h5A);
    consume();

    // Randomized loopback traffic through both scoreboards.
    loop = 1'b1;
    deq_ready = 1'b1;
    rx_mon_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      rx_exp.push_back(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(b);
    end
    wait_ready();
    repeat (20) @(negedge clk);
    check("tx_queue_drained", tx_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);

    // Mid-frame reset aborts TX and RX.
    rx_mon_en = 1'b0;
    tx_mon_en = 1'b0;
    deq_ready = 1'b0;
    send(8'h00);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_txd_async", txd, 1);
    check("abort_enq_ready", enq_ready, 1);
    check("abort_deq_valid", deq_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (deq_valid) seen = 1'b1;
    end
    check("abort_no_partial_rx", seen, 0);
    check("abort_txd_idle", txd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are 4 to 65535.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-low reset; asserting it (low) resets the block.
REQ-004 The block SHALL have port io_ctl_enq_valid, input, 1, a TX byte-offer strobe.
REQ-005 The block SHALL have port io_ctl_enq_bits, input, 8, the TX byte.
REQ-006 The block SHALL have port io_ctl_enq_ready, output, 1, indicating the transmitter can accept a byte.
REQ-007 The block SHALL have port io_ctl_deq_valid, output, 1, indicating a received byte is available.
REQ-008 The block SHALL have port io_ctl_deq_bits, output, 8, the received byte.
REQ-009 The block SHALL have port io_ctl_deq_ready, input, 1, the consumer acknowledging the received byte.
REQ-010 The block SHALL have port io_pins_rxd, input, 1, serial input that idles high and is asynchronous to clk.
REQ-011 The block SHALL have port io_pins_txd, output, 1, serial output that idles high.

Function
REQ-012 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-013 TX states SHALL be IDLE, START, DATA, STOP, with io_ctl_enq_ready=1 only in IDLE.
REQ-014 A TX byte SHALL be accepted on a clock edge where io_ctl_enq_valid && io_ctl_enq_ready; the byte is latched and the FSM enters START.
REQ-015 io_pins_txd SHALL go low on the first cycle after acceptance, a latency of 1 cycle.
REQ-016 The TX frame SHALL occupy 10*CLKS_PER_BIT cycles, after which the FSM returns to IDLE with io_pins_txd=1 and io_ctl_enq_ready=1 on the next cycle.
REQ-017 Changes to io_ctl_enq_bits or io_ctl_enq_valid during a TX frame SHALL have no effect.
REQ-018 Back-to-back TX SHALL be supported: with io_ctl_enq_valid held high, the next start bit immediately follows the previous stop bit plus 1 idle cycle.
REQ-019 io_pins_rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-021 In IDLE, RX SHALL enter START on a synchronized low level.
REQ-022 In START, RX SHALL re-sample the line after CLKS_PER_BIT/2 cycles; if high it returns to IDLE (glitch), if low it enters DATA.
REQ-023 In DATA, RX SHALL sample each data bit at mid-bit, every CLKS_PER_BIT cycles, assembling the byte LSB first.
REQ-024 In STOP, RX SHALL sample at mid-bit; if high, it writes the byte to the holding register, sets io_ctl_deq_valid=1 the next cycle, and returns to IDLE.
REQ-025 If the stop sample is low (framing error), RX SHALL discard the byte, leave io_ctl_deq_valid unchanged, and enter WAIT_IDLE.
REQ-026 RX SHALL stay in WAIT_IDLE until the synchronized line is high, then go to IDLE.
REQ-027 io_ctl_deq_bits SHALL be stable while io_ctl_deq_valid=1 and no new byte completes.
REQ-028 io_ctl_deq_valid SHALL clear on the cycle after io_ctl_deq_valid && io_ctl_deq_ready.
REQ-029 Overrun: a completed byte while io_ctl_deq_valid=1 SHALL overwrite the holding register, with io_ctl_deq_valid staying 1.
REQ-030 If a byte completes on the same cycle it is dequeued, the new byte SHALL be loaded and io_ctl_deq_valid stays 1.
REQ-031 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-032 While reset=0, both FSMs SHALL be in IDLE, bit and baud counters 0, io_pins_txd=1, io_ctl_enq_ready=1, io_ctl_deq_valid=0, io_ctl_deq_bits=8'h00, and synchronizer flops=1.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with io_pins_txd returning high asynchronously.
REQ-034 No partial RX byte SHALL be delivered after a mid-frame reset.

Structure
REQ-035 Package uart_pkg SHALL hold the TX/RX state enums, DATA_BITS=8, and the frame-length constants.
REQ-036 RX SHALL be one sub-module, uart_rx, covering the synchronizer, RX FSM and holding register.
REQ-037 TX SHALL be implemented in the top-level uart_core.

Verification (CLKS_PER_BIT=4)
REQ-038 Reset low then high: io_pins_txd=1, io_ctl_enq_ready=1, io_ctl_deq_valid=0.
REQ-039 Accept io_ctl_enq_bits=8'hFE with io_ctl_enq_valid=1: io_ctl_enq_ready drops next cycle, and io_pins_txd carries 0,0,1,1,1,1,1,1,1,1 with 4 cycles per bit, then ready returns.
REQ-040 Loop io_pins_txd to io_pins_rxd and send 8'hA5 with io_ctl_deq_ready=0: io_ctl_deq_valid=1 and io_ctl_deq_bits=8'hA5; pulsing io_ctl_deq_ready clears valid next cycle.
REQ-041 Hold io_pins_rxd=0 continuously: framing error, io_ctl_deq_valid stays 0, and no further byte until the line goes high and then receives a valid 8'h3C.
REQ-042 Send two bytes 8'h11 then 8'h22 without dequeuing: io_ctl_deq_bits=8'h22 and io_ctl_deq_valid=1.
REQ-043 Apply a 1-cycle low glitch on io_pins_rxd: no byte is received and RX is back in IDLE.
